ip_rx: RTL

IPv4 receive stage that sits directly downstream of the MAC receive stage. It consumes the MAC payload byte stream and EtherType, and drops anything that is not EtherType 0x0800. For IPv4 frames it parses and checks the header, filters on destination IP, trims Ethernet padding, and forwards the IP payload bytes plus header metadata to the UDP/ICMP receive stages.

---
 rtl/ip_rx_pkg.sv | 26 ++
 rtl/ip_checksum_acc.sv | 55 +++++
 rtl/ip_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ip_rx_pkg.sv
// Shared constants, header byte offsets and FSM state type for the IPv4 receive stage.
package ip_rx_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [3:0]  IP_VERSION    = 4'd4;
    localparam logic [3:0]  IHL_MIN       = 4'd5;

    localparam logic [15:0] TOTLEN_OFS = 16'd2;
    localparam logic [15:0] FRAG_OFS   = 16'd6;
    localparam logic [15:0] PROTO_OFS  = 16'd9;
    localparam logic [15:0] SRC_OFS    = 16'd12;
    localparam logic [15:0] DST_OFS    = 16'd16;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } ip_rx_state_t;

    // Header length in bytes from the IHL field (32-bit words).
    function automatic logic [15:0] hdr_bytes(input logic [3:0] ihl);
        return {10'd0, ihl, 2'b00};
    endfunction

endpackage

// File: rtl/ip_checksum_acc.sv
// Byte-serial one's-complement accumulator for the IPv4 header checksum.
// o_sum is the twice-folded sum including the byte currently on i_data.
module ip_checksum_acc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_sum
);

    logic [31:0] acc;
    logic [7:0]  hi_byte;
    logic        odd;

    logic [31:0] base;
    logic        odd_base;
    logic [31:0] acc_ahead;
    logic [16:0] fold1;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        base      = i_clr ? 32'd0 : acc;
        odd_base  = i_clr ? 1'b0 : odd;
        acc_ahead = base;
        if (i_en) begin
            acc_ahead = odd_base ? base + {16'd0, hi_byte, i_data}
                                 : base + {16'd0, i_data, 8'h00};
        end
        fold1 = {1'b0, acc_ahead[15:0]} + {1'b0, acc_ahead[31:16]};
        o_sum = fold1[15:0] + {15'd0, fold1[16]};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            hi_byte <= '0;
            odd     <= 1'b0;
        end else if (i_en) begin
            if (odd_base) begin
                acc <= acc_ahead;
                odd <= 1'b0;
            end else begin
                acc     <= base;
                hi_byte <= i_data;
                odd     <= 1'b1;
            end
        end else if (i_clr) begin
            acc <= '0;
            odd <= 1'b0;
        end
    end

endmodule

// File: rtl/ip_rx.sv
// IPv4 receive stage: parses and validates the header, filters on destination IP,
// strips Ethernet padding and forwards the payload with registered metadata.
module ip_rx
    import ip_rx_pkg::*;
#(
    parameter logic [31:0] P_TARGET_IP      = {8'd192, 8'd168, 8'd1, 8'd100},
    parameter bit          P_CHECKSUM_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_target_ip,
    input  logic        i_target_ip_valid,
    input  logic [15:0] i_mac_type,
    input  logic [7:0]  i_mac_data,
    input  logic        i_mac_last,
    input  logic        i_mac_valid,
    output logic [7:0]  o_ip_protocol,
    output logic [31:0] o_ip_src_ip,
    output logic [15:0] o_ip_data_len,
    output logic [7:0]  o_ip_data,
    output logic        o_ip_last,
    output logic        o_ip_valid,
    output logic        o_ip_err
);

    ip_rx_state_t state;
    logic [15:0]  cnt;
    logic [15:0]  rem;
    logic [31:0]  local_ip;

    logic [3:0]   ver;
    logic [3:0]   ihl;
    logic [15:0]  tot_len;
    logic [13:0]  frag;
    logic [7:0]   proto;
    logic [31:0]  src_ip;
    logic [31:0]  dst_ip;

    logic [15:0]  csum;
    logic         csum_clr;
    logic         csum_en;

    logic [15:0]  hdr_len;
    logic         hdr_last;
    logic [31:0]  dst_now;
    logic [15:0]  data_len;
    logic         hdr_ok;

    assign csum_clr = (state == IDLE);
    assign csum_en  = i_mac_valid &&
                      (((state == IDLE) && (i_mac_type == ETH_TYPE_IPV4)) || (state == HDR));

    ip_checksum_acc u_csum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (csum_clr),
        .i_en   (csum_en),
        .i_data (i_mac_data),
        .o_sum  (csum)
    );

    // A short IHL still parses the fixed 20-byte header, then fails the IHL check.
    always_comb begin
        hdr_len  = hdr_bytes(ihl);
        hdr_last = (ihl < IHL_MIN) ? (cnt == DST_OFS + 16'd3) : (cnt == hdr_len - 16'd1);
        dst_now  = (cnt == DST_OFS + 16'd3) ? {dst_ip[23:0], i_mac_data} : dst_ip;
        data_len = tot_len - hdr_len;
        hdr_ok   = (ver == IP_VERSION) && (ihl >= IHL_MIN) && (tot_len >= hdr_len) &&
                   (frag == 14'd0) &&
                   ((dst_now == local_ip) || (dst_now == 32'hFFFF_FFFF)) &&
                   (!P_CHECKSUM_CHECK || (csum == 16'hFFFF));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            local_ip      <= P_TARGET_IP;
            ver           <= '0;
            ihl           <= '0;
            tot_len       <= '0;
            frag          <= '0;
            proto         <= '0;
            src_ip        <= '0;
            dst_ip        <= '0;
            o_ip_protocol <= '0;
            o_ip_src_ip   <= '0;
            o_ip_data_len <= '0;
            o_ip_data     <= '0;
            o_ip_last     <= 1'b0;
            o_ip_valid    <= 1'b0;
            o_ip_err      <= 1'b0;
        end else begin
            o_ip_valid <= 1'b0;
            o_ip_last  <= 1'b0;
            o_ip_err   <= 1'b0;

            if (i_target_ip_valid) local_ip <= i_target_ip;

            cnt <= (i_mac_valid && !i_mac_last) ? cnt + 16'd1 : 16'd0;

            if (i_mac_valid && (state == IDLE || state == HDR)) begin
                if (cnt == 16'd0)               {ver, ihl}     <= i_mac_data;
                if (cnt == TOTLEN_OFS)          tot_len[15:8]  <= i_mac_data;
                if (cnt == TOTLEN_OFS + 16'd1)  tot_len[7:0]   <= i_mac_data;
                if (cnt == FRAG_OFS)            frag[13:8]     <= i_mac_data[5:0];
                if (cnt == FRAG_OFS + 16'd1)    frag[7:0]      <= i_mac_data;
                if (cnt == PROTO_OFS)           proto          <= i_mac_data;
                if (cnt >= SRC_OFS && cnt < SRC_OFS + 16'd4) src_ip <= {src_ip[23:0], i_mac_data};
                if (cnt >= DST_OFS && cnt < DST_OFS + 16'd4) dst_ip <= {dst_ip[23:0], i_mac_data};
            end

            case (state)
                IDLE: begin
                    if (i_mac_valid) begin
                        if (i_mac_type == ETH_TYPE_IPV4) begin
                            if (i_mac_last) o_ip_err <= 1'b1;
                            else            state    <= HDR;
                        end else if (!i_mac_last) begin
                            state <= DROP;
                        end
                    end
                end

                HDR: begin
                    if (!i_mac_valid) begin
                        o_ip_err <= 1'b1;
                        state    <= IDLE;
                    end else if (hdr_last) begin
                        if (hdr_ok) begin
                            o_ip_protocol <= proto;
                            o_ip_src_ip   <= src_ip;
                            o_ip_data_len <= data_len;
                            rem           <= data_len;
                            // Empty payload: swallow any Ethernet padding instead of reparsing it.
                            if (data_len == 16'd0) begin
                                state <= i_mac_last ? IDLE : DROP;
                            end else if (i_mac_last) begin
                                o_ip_err <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end else begin
                            state <= i_mac_last ? IDLE : DROP;
                        end
                    end else if (i_mac_last) begin
                        o_ip_err <= 1'b1;
                        state    <= IDLE;
                    end
                end

                PAYLOAD: begin
                    if (!i_mac_valid) begin
                        // The final byte has already left; only the error can still be flagged.
                        o_ip_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        o_ip_valid <= 1'b1;
                        o_ip_data  <= i_mac_data;
                        rem        <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            o_ip_last <= 1'b1;
                            state     <= i_mac_last ? IDLE : DROP;
                        end else if (i_mac_last) begin
                            o_ip_last <= 1'b1;
                            o_ip_err  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                DROP: begin
                    if (!i_mac_valid || i_mac_last) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
